mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer for the RV32M subset. Sits in EX beside the ALU.
//  Main/ALU decoders route OP (0110011) with funct7=0000001 here, not to the ALU.
//  Runs a shift-add multiply or restoring divide over XLEN cycles.
//  Drives stall to the hazard unit so IF/ID/EX hold while busy.
//  Returns a single-cycle done pulse with the result for the EX/MEM register.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN; counter width = $clog2(XLEN)
// PORTS
//  clk     in   1     single clock, all state updates on rising edge
//  rst     in   1     synchronous, active-high reset
//  start   in   1     EX holds a valid M-instruction; sampled only in IDLE
//  funct3  in   3     instr[14:12]; selects operation (see BEHAVIOUR)
//  src_a   in   XLEN  rs1 value (multiplicand / dividend)
//  src_b   in   XLEN  rs2 value (multiplier / divisor)
//  flush   in   1     branch/jump flush from EX; aborts any operation in progress
//  busy    out  1     1 in RUN or DONE
//  stall   out  1     combinational: start&&IDLE&&!flush || state==RUN
//  done    out  1     1 for exactly one cycle (DONE state); result valid then
//  result  out  XLEN  registered result; holds last value until next DONE
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  FSM: IDLE -> RUN on start && !flush.
//       RUN -> DONE after XLEN iterations.
//       DONE -> IDLE unconditionally.
//       Any state -> IDLE on flush (done never pulses; result unchanged).
//  Start/latency:
//   - start in IDLE at edge k latches funct3 and operands (magnitudes if signed).
//   - RUN spans cycles k+1..k+XLEN; done=1 in cycle k+XLEN+1; back in IDLE at k+XLEN+2.
//   - stall is 1 from the start cycle through the last RUN cycle and 0 in DONE.
//   - EX/MEM captures result on the DONE edge.
//  start outside IDLE is ignored. flush && start in the same IDLE cycle: flush wins, no start.
//  rst mid-operation: IDLE next cycle; no done; result returns to 0.
//  funct3 map:
//   000 MUL (low XLEN)   011 MULHU (high XLEN)   101 DIVU   111 REMU
//   001 MULH   010 MULHSU   100 DIV   110 REM   (signed, see CONFIGURATION)
//  Multiply:
//   - 2*XLEN product register.
//   - Each RUN cycle: if multiplier LSB=1, add multiplicand to upper half; then shift right 1, carry kept.
//  Divide (restoring):
//   - Each RUN cycle: shift {rem,quot} left 1; trial = rem - divisor (XLEN+1 bits).
//   - If trial is non-negative: rem = trial, quot LSB = 1.
//  Divide-by-zero needs no special case; the algorithm yields quotient=all-ones, rem=dividend.
//  No exceptions raised; all arithmetic is modulo 2^XLEN on outputs.
// CONFIGURATION
//  MDU_SIGNED_EN defined:
//   - Signed codes use magnitude conversion at start; sign fix-up is applied when entering DONE.
//   - MUL/MULH: product negated if sign(a)^sign(b). MULHSU: only a is treated as signed.
//   - DIV: quotient negated iff sign(a)^sign(b) and divisor!=0.
//   - REM: remainder takes the sign of the dividend.
//   - Results: x/0 = -1; x%0 = x; 0x80000000/-1 = 0x80000000; 0x80000000%-1 = 0.
//  MDU_SIGNED_EN undefined: signed codes alias to unsigned ops, with no sign logic.
//   - 001,010 -> MULHU; 100 -> DIVU; 110 -> REMU.
// TESTING
//  1 MUL 7*6, start at cycle 0 -> stall cycles 0..32, done and result=42 in cycle 33, busy=0 in cycle 34.
//  2 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL with same operands -> 0x00000001.
//  3 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
//  4 flush on RUN cycle 10 -> no done, busy=0 next cycle, result unchanged; new start then completes normally.
//  5 rst in RUN cycle 5 -> IDLE with all outputs 0 next cycle; start while busy is ignored.
//  6 [MDU_SIGNED_EN] cases:
//    DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
//    DIV 0x80000000/-1 -> 0x80000000; MULH -1*-1 -> 0.
//    Without the macro, DIV -7/2 gives the DIVU result 0x7FFFFFFC.

Source files
------------

// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - EX-stage request/response bundle between the pipeline and mdu_seq
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative shift-add multiply / restoring divide sequencer for RV32M
// Signed codes (MULH, MULHSU, DIV, REM) are honoured only when MDU_SIGNED_EN is defined.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  mdu_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quot;
  logic [2*XLEN-1:0] prod;

  logic [XLEN-1:0]   a_in;
  logic [XLEN-1:0]   b_in;

`ifdef MDU_SIGNED_EN
  logic sa;
  logic sb;
  logic neg_in;
  logic neg_res;

  // Operands enter the datapath as magnitudes; neg_in records the sign fix-up owed at DONE.
  always_comb begin
    sa = bus.src_a[XLEN-1] && (bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    sb = bus.src_b[XLEN-1] && (bus.funct3 inside {3'b001, 3'b100, 3'b110});
    a_in = sa ? -bus.src_a : bus.src_a;
    b_in = sb ? -bus.src_b : bus.src_b;
    case (bus.funct3)
      3'b110:  neg_in = sa;
      3'b100:  neg_in = (sa ^ sb) && (bus.src_b != '0);
      default: neg_in = sa ^ sb;
    endcase
  end
`else
  assign a_in = bus.src_a;
  assign b_in = bus.src_b;
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_nxt;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quot_nxt;

  // Both datapaths step every RUN cycle; op only chooses which one is reported.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt  = {mul_sum, prod[XLEN-1:1]};
    div_trial = {rem, quot[XLEN-1]} - {1'b0, divisor};
    if (!div_trial[XLEN]) begin
      rem_nxt  = div_trial[XLEN-1:0];
      quot_nxt = {quot[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt  = {rem[XLEN-2:0], quot[XLEN-1]};
      quot_nxt = {quot[XLEN-2:0], 1'b0};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_nxt;

  // Result as it will stand after the final iteration, sign-corrected.
  always_comb begin
    prod_fix = prod_nxt;
    quot_fix = quot_nxt;
    rem_fix  = rem_nxt;
`ifdef MDU_SIGNED_EN
    if (neg_res) begin
      prod_fix = -prod_nxt;
      quot_fix = -quot_nxt;
      rem_fix  = -rem_nxt;
    end
`endif
    case (op)
      3'b000:                 res_nxt = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_nxt = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_nxt = quot_fix;
      default:                res_nxt = rem_fix;
    endcase
  end

  assign bus.stall = (bus.start && (state == IDLE) && !bus.flush) || (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      mcand      <= '0;
      divisor    <= '0;
      rem        <= '0;
      quot       <= '0;
      prod       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
`ifdef MDU_SIGNED_EN
      neg_res    <= 1'b0;
`endif
    end else if (bus.flush) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            cnt      <= '0;
            op       <= bus.funct3;
            mcand    <= a_in;
            prod     <= {{XLEN{1'b0}}, b_in};
            divisor  <= b_in;
            quot     <= a_in;
            rem      <= '0;
            bus.busy <= 1'b1;
`ifdef MDU_SIGNED_EN
            neg_res  <= neg_in;
`endif
          end
        end
        RUN: begin
          prod <= prod_nxt;
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.result <= res_nxt;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq: directed RV32M cases plus randomized ops
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mdu_seq_if #(.XLEN(32)) bus ();

  mdu_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit / int arithmetic following the RV32M definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] f_in, input logic [31:0] a, input logic [31:0] b);
    logic [2:0]         f;
    logic signed [63:0] as, bs, au, bu;
    logic [63:0]        p;
    int                 ia, ib;
    f = f_in;
`ifndef MDU_SIGNED_EN
    if (f == 3'b001 || f == 3'b010) f = 3'b011;
    else if (f == 3'b100) f = 3'b101;
    else if (f == 3'b110) f = 3'b111;
`endif
    as = {{32{a[31]}}, a};
    bs = {{32{b[31]}}, b};
    au = {32'b0, a};
    bu = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'b000: begin p = au * bu; return p[31:0]; end
      3'b001: begin p = as * bs; return p[63:32]; end
      3'b010: begin p = as * bu; return p[63:32]; end
      3'b011: begin p = au * bu; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_spurious: done with result %h but no operation expected", bus.result);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        check("result", bus.result, e);
        last_res = e;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(bus.busy), 32'h0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src_a  = a;
    bus.src_b  = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    wait_idle();
    sb_q.push_back(exp);
    issue(f, a, b);
    wait_idle();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        bad;
    logic [2:0]  f;
    logic [31:0] a, b;

    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // MUL 7*6 with cycle-exact timing relative to the start cycle
    sb_q.push_back(32'd42);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'd7; bus.src_b = 32'd6;
    #1 check("stall_start_cycle", 32'(bus.stall), 32'h1);
    bad = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (c <= 32) begin
        if (!bus.stall || bus.done) bad = 1'b1;
      end else begin
        check("run_stall_no_done", 32'(bad), 32'h0);
        check("done_c33", 32'(bus.done), 32'h1);
        check("stall_done_c33", 32'(bus.stall), 32'h0);
        check("busy_done_c33", 32'(bus.busy), 32'h1);
        check("result_c33", bus.result, 32'd42);
      end
    end
    @(negedge clk);
    #1 check("busy_c34", 32'(bus.busy), 32'h0);

    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(3'b101, 32'd100, 32'd7, 32'd14);
    run_op(3'b111, 32'd100, 32'd7, 32'd2);
    run_op(3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF);
    run_op(3'b111, 32'h1234, 32'h0, 32'h1234);
`ifdef MDU_SIGNED_EN
    run_op(3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    run_op(3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
`else
    run_op(3'b100, -32'sd7, 32'd2, 32'h7FFF_FFFC);
    run_op(3'b110, -32'sd7, 32'd2, 32'h0000_0001);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`endif

    // flush during RUN cycle 10
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.src_a = 32'd999; bus.src_b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_busy", 32'(bus.busy), 32'h0);
    check("flush_done", 32'(bus.done), 32'h0);
    check("flush_result_held", bus.result, last_res);
    repeat (40) @(negedge clk);
    run_op(3'b000, 32'd1000, 32'd1000, 32'd1000000);

    // flush and start together in IDLE
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    #1 check("flush_start_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1 check("flush_start_busy", 32'(bus.busy), 32'h0);

    // reset during RUN cycle 5
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b011; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_done", 32'(bus.done), 32'h0);
    check("midrst_result", bus.result, 32'h0);
    check("midrst_stall", 32'(bus.stall), 32'h0);
    repeat (40) @(negedge clk);

    // start while busy is ignored
    wait_idle();
    sb_q.push_back(32'd6);
    issue(3'b101, 32'd20, 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b000; bus.src_a = 32'd11; bus.src_b = 32'd13;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    #1 check("no_restart_busy", 32'(bus.busy), 32'h0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(f, a, b, ref_res(f, a, b));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
